// File: rtl/aes_round_sequencer_if.sv
// Block stream bundle for the AES round sequencer: plaintext in, ciphertext out.
interface aes_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller driving one shared external round datapath.
// Optional abort input enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int RK_IDX_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_round_sequencer_if.slave bus,
    input  logic                key_valid,
    output logic                key_busy,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic [127:0]        dp_state,
    output logic                dp_last,
    input  logic [127:0]        dp_result
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic                abort
`endif
);

    if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
        $error("NUM_ROUNDS must be 10, 12 or 14");
    end
    if ((1 << RK_IDX_W) <= NUM_ROUNDS) begin : g_bad_idx_w
        $error("RK_IDX_W too narrow for NUM_ROUNDS");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } st_t;

    localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(NUM_ROUNDS);

    st_t                 st_q, st_d;
    logic [RK_IDX_W-1:0] round_q, round_d;
    logic [127:0]        state_q, state_d;
    logic                in_ready_c;
    logic                load;
    logic                kill;

`ifdef AES_SEQ_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    assign load          = bus.in_valid && in_ready_c;
    assign bus.in_ready  = rst_n && in_ready_c;
    assign bus.out_valid = rst_n && (st_q == DONE);
    assign bus.out_data  = state_q;
    assign dp_state      = state_q;

    always_comb begin
        st_d       = st_q;
        round_d    = round_q;
        state_d    = state_q;
        in_ready_c = 1'b0;
        rk_idx     = '0;
        dp_last    = 1'b0;
        key_busy   = 1'b1;
        unique case (st_q)
            IDLE: begin
                key_busy   = 1'b0;
                in_ready_c = key_valid;
                if (load) begin
                    state_d = bus.in_data ^ rk_data;
                    round_d = RK_IDX_W'(1);
                    st_d    = RUN;
                end
            end
            RUN: begin
                rk_idx  = round_q;
                dp_last = (round_q == LAST);
                state_d = dp_result;
                if (round_q == LAST) begin
                    st_d = DONE;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            DONE: begin
                // An abort also blocks the back-to-back load in this cycle
                in_ready_c = bus.out_ready && key_valid && !kill;
                if (bus.out_ready) begin
                    if (load) begin
                        state_d = bus.in_data ^ rk_data;
                        round_d = RK_IDX_W'(1);
                        st_d    = RUN;
                    end else begin
                        round_d = '0;
                        st_d    = IDLE;
                    end
                end
            end
            default: begin
                round_d = '0;
                st_d    = IDLE;
            end
        endcase
        if (kill && st_q != IDLE) begin
            round_d = '0;
            st_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            round_q <= '0;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

endmodule
